// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg
//   Shared types and default configuration for the clock-enable generator:
//   the sequencer state encoding and the default parameter values used by
//   clk_en_gen, clk_en_gen_if and the bench.
package clk_en_gen_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_HALT      = 2'd3
    } state_e;

    localparam int DEF_NUM_CH        = 2;
    localparam int DEF_DIV_W         = 8;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/clk_en_gen_if.sv
// clk_en_gen_if
//   Bundles the divide-programming inputs and the generator status outputs.
//   Ports (signals):
//     div_in        NUM_CH*DIV_W  packed divide values, channel 0 in LSBs
//     div_load_in   1             one-cycle strobe capturing div_in
//     sys_rst_n_out 1             registered system reset, high only in RUN
//     ce_out        NUM_CH        per-channel one-cycle clock-enable pulses
//     running_out   1             high while in RUN
//     lock_lost_out 1             sticky: lock dropped while in RUN
//   Modports: master (programs dividers, observes status), slave (generator).
interface clk_en_gen_if
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIV_W  = DEF_DIV_W
) ();

    logic [NUM_CH*DIV_W-1:0] div_in;
    logic                    div_load_in;
    logic                    sys_rst_n_out;
    logic [NUM_CH-1:0]       ce_out;
    logic                    running_out;
    logic                    lock_lost_out;

    modport master (
        output div_in, div_load_in,
        input  sys_rst_n_out, ce_out, running_out, lock_lost_out
    );

    modport slave (
        input  div_in, div_load_in,
        output sys_rst_n_out, ce_out, running_out, lock_lost_out
    );

endinterface

// File: rtl/sync_ff.sv
// sync_ff
//   Multi-flop synchroniser for a single asynchronous level signal.
//   Ports:
//     clk_in   destination clock
//     rst_n_in asynchronous active-low reset (clears all stages to 0)
//     d_in     asynchronous input
//     q_out    synchronised output, STAGES cycles of latency
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) ff <= '0;
        else           ff <= {ff[STAGES-2:0], d_in};
    end

    assign q_out = ff[STAGES-1];

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen
//   Waits for a synchronised PLL lock to stay high for STABLE_CYCLES, then
//   releases the system reset and produces per-channel clock-enable pulses
//   at programmable divide ratios.
//   Ports:
//     clk_in        single clock, all logic on its rising edge
//     rst_n_in      asynchronous active-low reset
//     pll_locked_in PLL lock, asynchronous to clk_in
//     bus           clk_en_gen_if.slave (div_in, div_load_in, sys_rst_n_out,
//                   ce_out, running_out, lock_lost_out)
//   Build option: CLK_EN_GEN_LOCK_RECOVERY_EN -- when defined, losing lock in
//   RUN returns to WAIT_LOCK and re-qualifies; otherwise the block parks in
//   HALT until reset.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int DIV_W         = DEF_DIV_W,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         pll_locked_in,
    clk_en_gen_if.slave  bus
);

    localparam int                SC_W    = $clog2(STABLE_CYCLES);
    localparam logic [SC_W-1:0]   SC_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE = DIV_W'(1);

    logic            lock_s;
    state_e          state;
    logic [SC_W-1:0] stable_cnt;
    logic            running;
    logic            sys_rst_n;
    logic            lock_lost;
    logic [NUM_CH-1:0] ce;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (pll_locked_in),
        .q_out    (lock_s)
    );

    // Sequencer. running/sys_rst_n are written alongside the state so they
    // are plain flops that track (state == ST_RUN) with no extra delay.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= ST_WAIT_LOCK;
            stable_cnt <= '0;
            running    <= 1'b0;
            sys_rst_n  <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state      <= ST_STABLE;
                        stable_cnt <= '0;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state <= ST_WAIT_LOCK;
                    end else if (stable_cnt == SC_LAST) begin
                        state     <= ST_RUN;
                        running   <= 1'b1;
                        sys_rst_n <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        lock_lost <= 1'b1;
                        running   <= 1'b0;
                        sys_rst_n <= 1'b0;
`ifdef CLK_EN_GEN_LOCK_RECOVERY_EN
                        state     <= ST_WAIT_LOCK;
`else
                        state     <= ST_HALT;
`endif
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_WAIT_LOCK;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] act_div;
        logic [DIV_W-1:0] pend_div;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] last;
        logic [DIV_W-1:0] nxt_pend;
        logic             tc;

        // A load in the same cycle bypasses the pending register so a value
        // written on the terminal-count cycle applies to the next period.
        assign nxt_pend = bus.div_load_in ? bus.div_in[i*DIV_W +: DIV_W] : pend_div;
        // Divide values 0 and 1 both mean "every cycle".
        assign last     = (act_div <= DIV_ONE) ? '0 : act_div - DIV_ONE;
        assign tc       = (cnt == last);
        assign ce[i]    = running & tc;

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                act_div  <= DIV_ONE;
                pend_div <= DIV_ONE;
                cnt      <= '0;
            end else begin
                pend_div <= nxt_pend;
                if (!running || tc) act_div <= nxt_pend;
                // !lock_s while running is exactly the RUN-exit edge, so the
                // counter is already 0 in the first cycle outside RUN.
                if (!running || !lock_s || tc) cnt <= '0;
                else                           cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.ce_out        = ce;
    assign bus.sys_rst_n_out = sys_rst_n;
    assign bus.running_out   = running;
    assign bus.lock_lost_out = lock_lost;

endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int STABLE = 16;
    localparam int SYNC   = 2;
    localparam int EW     = NUM_CH + 3;
`ifdef CLK_EN_GEN_LOCK_RECOVERY_EN
    localparam int REC = 1;
`else
    localparam int REC = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pll   = 1'b0;

    clk_en_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    clk_en_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .pll_locked_in (pll),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] expq[$];
    int n_chk  = 0;
    int n_pass = 0;
    int pulses[$];
    int run_idx = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: lock qualification as "consecutive synchronised-high
    // edges", channel pulses as absolute RUN-cycle indices of the next pulse.
    int m_run, m_lost, m_halt, m_streak, m_t;
    int hist[SYNC];
    int m_act[NUM_CH];
    int m_pend[NUM_CH];
    int m_np[NUM_CH];

    function automatic int eff(input int a);
        return (a <= 1) ? 1 : a;
    endfunction

    always @(posedge clk) begin
        logic [EW-1:0] e;
        int ls, was_run, tc, newp;
        if (!rst_n) begin
            m_run = 0; m_lost = 0; m_halt = 0; m_streak = 0; m_t = 0;
            for (int s = 0; s < SYNC; s++) hist[s] = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_act[c] = 1; m_pend[c] = 1; m_np[c] = 0;
            end
        end else begin
            ls = hist[SYNC-1];
            for (int s = SYNC-1; s > 0; s--) hist[s] = hist[s-1];
            hist[0] = int'(pll);
            was_run = m_run;
            for (int c = 0; c < NUM_CH; c++) begin
                tc   = (was_run != 0 && m_t == m_np[c]) ? 1 : 0;
                newp = bus.div_load_in ? int'(bus.div_in[c*DIV_W +: DIV_W]) : m_pend[c];
                m_pend[c] = newp;
                if (was_run == 0 || tc != 0) m_act[c] = newp;
                if (tc != 0) m_np[c] = m_t + eff(m_act[c]);
            end
            if (was_run != 0) begin
                if (ls == 0) begin
                    m_run = 0; m_lost = 1; m_streak = 0;
                    m_halt = (REC != 0) ? 0 : 1;
                end
            end else if (m_halt == 0) begin
                if (ls != 0) begin
                    m_streak++;
                    if (m_streak == STABLE + 1) begin
                        m_run = 1; m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            if (m_run != 0 && was_run == 0) begin
                m_t = 0;
                for (int c = 0; c < NUM_CH; c++) m_np[c] = eff(m_act[c]) - 1;
            end else if (m_run != 0) begin
                m_t++;
            end
        end
        e = '0;
        e[EW-1] = (m_run != 0);
        e[EW-2] = (m_run != 0);
        e[EW-3] = (m_lost != 0);
        for (int c = 0; c < NUM_CH; c++) e[c] = (m_run != 0 && m_t == m_np[c]);
        expq.push_back(e);
    end

    // Monitor: pops one expectation per cycle, compares mid-cycle.
    always @(negedge clk) begin
        logic [EW-1:0] a, e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {bus.sys_rst_n_out, bus.running_out, bus.lock_lost_out, bus.ce_out};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL outputs @%0t: got sys/run/lost/ce=%b expected %b", $time, a, e);
        end
        if (bus.running_out === 1'b1) begin
            if (bus.ce_out[0] === 1'b1) pulses.push_back(run_idx);
            run_idx++;
        end else begin
            run_idx = 0;
        end
    end

    task automatic neg_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_release(input string name, output int rel);
        int found;
        found = 0;
        rel   = 0;
        for (int e = 1; e <= 60 && found == 0; e++) begin
            tick();
            if (bus.sys_rst_n_out === 1'b1) begin
                found = 1;
                rel   = e;
            end
        end
        if (found == 0) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int rel;
        bus.div_in      = '0;
        bus.div_load_in = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("reset_sys", int'(bus.sys_rst_n_out), 0);
        check("reset_lost", int'(bus.lock_lost_out), 0);

        // Program {ch1=1, ch0=4} before release, then qualify lock.
        bus.div_in = {8'd1, 8'd4};
        bus.div_load_in = 1'b1;
        tick();
        bus.div_load_in = 1'b0;
        pll = 1'b1;
        wait_release("release", rel);
        check("release_cycle", rel, SYNC + STABLE + 1);
        pulses.delete();

        // Reload ch0 to 6 during RUN cycle 5.
        repeat (5) tick();
        bus.div_in = {8'd1, 8'd6};
        bus.div_load_in = 1'b1;
        tick();
        bus.div_load_in = 1'b0;
        repeat (16) tick();
        check("reload_pulse_count", pulses.size(), 4);
        if (pulses.size() > 0) check("reload_p0", pulses[0], 3);
        if (pulses.size() > 1) check("reload_p1", pulses[1], 7);
        if (pulses.size() > 2) check("reload_p2", pulses[2], 13);
        if (pulses.size() > 3) check("reload_p3", pulses[3], 19);

        // Lock loss: visible after the synchroniser plus one sequencer edge.
        pll = 1'b0;
        repeat (2) tick();
        check("loss_sys_before", int'(bus.sys_rst_n_out), 1);
        tick();
        check("loss_sys_after", int'(bus.sys_rst_n_out), 0);
        check("loss_ce_after", int'(bus.ce_out), 0);
        check("loss_sticky", int'(bus.lock_lost_out), 1);
        pll = 1'b1;
        repeat (40) tick();
        check("relock_running", int'(bus.running_out), REC);
        check("relock_sticky", int'(bus.lock_lost_out), 1);

        // Async reset between edges while running.
        neg_reset();
        wait_release("rerun", rel);
        check("rerun_cycle", rel, SYNC + STABLE + 1);
        tick();
        check("default_div_ce", int'(bus.ce_out), 3);
        repeat (3) tick();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_sys", int'(bus.sys_rst_n_out), 0);
        check("async_run", int'(bus.running_out), 0);
        check("async_ce", int'(bus.ce_out), 0);
        check("async_lost", int'(bus.lock_lost_out), 0);
        pll = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Divide 0 behaves as 1; lock glitch restarts qualification.
        bus.div_in = {8'd0, 8'd0};
        bus.div_load_in = 1'b1;
        tick();
        bus.div_load_in = 1'b0;
        pll = 1'b1;
        repeat (10) tick();
        check("glitch_not_yet", int'(bus.running_out), 0);
        pll = 1'b0;
        tick();
        pll = 1'b1;
        wait_release("glitch", rel);
        check("glitch_cycle", rel, SYNC + STABLE + 1);
        tick();
        check("div0_ce", int'(bus.ce_out), 3);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bus.div_load_in = ($urandom_range(0, 7) == 0);
            bus.div_in = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 9))};
            if (pll) begin
                if ($urandom_range(0, 199) == 0) pll = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                pll = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) begin
                bus.div_load_in = 1'b0;
                neg_reset();
            end else begin
                tick();
            end
        end
        bus.div_load_in = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
